// File: rtl/pulse_output.sv
// Stretches one-cycle events into timed ON/OFF pulses; surplus events queue up.
// Build option: PULSE_OUTPUT_RETRIGGER_EN makes ON-state triggers extend the pulse.
module pulse_output #(
  parameter int ON_CYCLES   = 4,
  parameter int OFF_CYCLES  = 2,
  parameter int QUEUE_DEPTH = 3,
  localparam int PW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trigger,
  output logic          out_level,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] QMAX     = PW'(QUEUE_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  logic [1:0]    state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [PW-1:0] pend_n;
  logic          ovf_n;
  logic          last_off;
  logic          q_push;

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    pend_n   = pending;
    ovf_n    = overflow;
    last_off = (state == S_OFF) && (timer == '0);
`ifdef PULSE_OUTPUT_RETRIGGER_EN
    q_push   = trigger && (state == S_OFF) && !last_off;
`else
    q_push   = trigger && (state != S_IDLE) && !last_off;
`endif

    if (q_push) begin
      if (pending == QMAX) ovf_n = 1'b1;
      else                 pend_n = pending + 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        if (trigger) begin
          state_n = S_ON;
          timer_n = ON_LOAD;
        end
      end
      S_ON: begin
`ifdef PULSE_OUTPUT_RETRIGGER_EN
        if (trigger) begin
          timer_n = ON_LOAD;
        end else
`endif
        if (timer == '0) begin
          state_n = S_OFF;
          timer_n = OFF_LOAD;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      S_OFF: begin
        if (timer != '0) begin
          timer_n = timer - 1'b1;
        end else if (trigger || pending != '0) begin
          // a same-edge trigger replaces the dequeued event
          state_n = S_ON;
          timer_n = ON_LOAD;
          if (!trigger) pend_n = pending - 1'b1;
        end else begin
          state_n = S_IDLE;
          timer_n = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
      out_level <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      pending   <= pend_n;
      overflow  <= ovf_n;
      out_level <= (state_n == S_ON);
      busy      <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_output.sv
// Directed bench for pulse_output with default parameters (ON=4, OFF=2, depth 3).
// Edge numbers are counted from the first edge after each reset release.
module tb_pulse_output;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trigger = 1'b0;
  logic       out_level;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  pulse_output dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .out_level (out_level),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input logic trig);
    trigger = trig;
    @(posedge clk);
    #1;
    trigger = 1'b0;
  endtask

  task automatic cmp(input string name, input int e, input logic [4:0] exp);
    checks++;
    if ({out_level, busy, pending, overflow} !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got out/busy/pend/ovf=%b required=%b",
               name, e, {out_level, busy, pending, overflow}, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({out_level, busy, pending, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_clear got=%b required=00000",
               {out_level, busy, pending, overflow});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_level, busy, pending, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state got=%b required=00000",
               {out_level, busy, pending, overflow});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic eo, eb;
    for (int e = 1; e <= 24; e++) begin
      step(e == 10);
      eo = (e >= 10 && e <= 13);
      eb = (e >= 10 && e <= 15);
      cmp("single", e, {eo, eb, 2'd0, 1'b0});
    end
  endtask

  task automatic test_queue();
    logic eo, eb;
    logic [1:0] ep;
    for (int e = 1; e <= 32; e++) begin
      step(e >= 10 && e <= 12);
      eo = (e >= 10 && e <= 13) || (e >= 16 && e <= 19) ||
           (e >= 22 && e <= 25);
      eb = (e >= 10 && e <= 27);
      ep = (e == 11) ? 2'd1 : (e >= 12 && e <= 15) ? 2'd2 :
           (e >= 16 && e <= 21) ? 2'd1 : 2'd0;
      cmp("queue", e, {eo, eb, ep, 1'b0});
    end
  endtask

  task automatic test_overflow();
    logic eo, eb, ev;
    logic [1:0] ep;
    logic prev;
    int rises;
    prev  = 1'b0;
    rises = 0;
    for (int e = 1; e <= 40; e++) begin
      step(e >= 10 && e <= 14);
      eo = (e >= 10 && e <= 13) || (e >= 16 && e <= 19) ||
           (e >= 22 && e <= 25) || (e >= 28 && e <= 31);
      eb = (e >= 10 && e <= 33);
      ev = (e >= 14);
      ep = (e == 11) ? 2'd1 : (e == 12) ? 2'd2 :
           (e >= 13 && e <= 15) ? 2'd3 : (e >= 16 && e <= 21) ? 2'd2 :
           (e >= 22 && e <= 27) ? 2'd1 : 2'd0;
      cmp("overflow", e, {eo, eb, ep, ev});
      if (out_level && !prev) rises++;
      prev = out_level;
    end
    checks++;
    if (rises !== 4) begin
      errors++;
      $display("FAIL overflow_pulse_count got=%0d required=4", rises);
    end
  endtask

  task automatic test_boundary();
    logic eo, eb;
    logic [1:0] ep;
    for (int e = 1; e <= 28; e++) begin
      step(e == 10 || e == 16);
      eo = (e >= 10 && e <= 13) || (e >= 16 && e <= 19);
      eb = (e >= 10 && e <= 21);
      cmp("boundary_p0", e, {eo, eb, 2'd0, 1'b0});
    end
    for (int e = 1; e <= 34; e++) begin
      step(e == 10 || e == 15 || e == 16);
      eo = (e >= 10 && e <= 13) || (e >= 16 && e <= 19) ||
           (e >= 22 && e <= 25);
      eb = (e >= 10 && e <= 27);
      ep = (e >= 15 && e <= 21) ? 2'd1 : 2'd0;
      cmp("boundary_p1", e, {eo, eb, ep, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    for (int e = 1; e <= 12; e++) begin
      step(e >= 10 && e <= 12);
    end
    cmp("pre_reset", 12, {1'b1, 1'b1, 2'd2, 1'b0});
    #2;
    rst = 1'b1;
    #1;
    cmp("async_reset", 12, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step(1'b0);
      cmp("post_reset", e, 5'b0);
    end
  endtask

  task automatic test_retrigger();
    logic eo, eb;
    logic [1:0] ep;
    for (int e = 1; e <= 28; e++) begin
      step(e == 10 || e == 12);
`ifdef PULSE_OUTPUT_RETRIGGER_EN
      eo = (e >= 10 && e <= 15);
      eb = (e >= 10 && e <= 17);
      ep = 2'd0;
`else
      eo = (e >= 10 && e <= 13) || (e >= 16 && e <= 19);
      eb = (e >= 10 && e <= 21);
      ep = (e >= 12 && e <= 15) ? 2'd1 : 2'd0;
`endif
      cmp("retrigger", e, {eo, eb, ep, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    do_reset();
    test_boundary();
    do_reset();
    test_retrigger();
`ifndef PULSE_OUTPUT_RETRIGGER_EN
    do_reset();
    test_queue();
    do_reset();
    test_overflow();
    do_reset();
    test_async_reset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
